addsub_seq_ctrl: RTL and testbench

ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_nibble.sv | 23 ++
 rtl/addsub_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_addsub_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// FSM state encoding, operation encoding and index sizing helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // A single-nibble datapath still needs a 1-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/addsub_nibble.sv
// Combinational 4-bit add/subtract slice; subtraction inverts b and relies
// on the caller feeding the +1 through cin on the first nibble.
module addsub_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] b_eff_s;
    logic [4:0] total_s;

    // One's-complement b for subtract, then a plain 4-bit add with carry-in.
    always_comb begin
        b_eff_s = sub ? ~b : b;
        total_s = {1'b0, a} + {1'b0, b_eff_s} + {4'b0000, cin};
        sum     = total_s[3:0];
        cout    = total_s[4];
    end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Sequential W-bit add/subtract: one 4-bit slice is reused for NIBBLES cycles,
// LS nibble first, with the inter-nibble carry held in a register.
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             op_q, op_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept_s;
    logic [3:0]       nib_a_s, nib_b_s, nib_sum_s;
    logic             nib_cout_s;

    assign nib_a_s = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b_s = b_q[{idx_q, 2'b00} +: 4];

    addsub_nibble u_nibble (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .cin  (carry_q),
        .sub  (op_q),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // Next-state, operand capture, per-nibble result update and flag generation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        // Carry starts at op so subtract becomes a + ~b + 1.
        if (accept_s) begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            idx_d   = '0;
            carry_d = op;
        end else begin
            a_d     = a_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = nib_sum_s;
                carry_d = nib_cout_s;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    cout_d  = nib_cout_s ^ op_q;
                    ovf_d   = (a_q[W-1] == (b_q[W-1] ^ op_q)) && (nib_sum_s[3] != a_q[W-1]);
                end else begin
                    state_d = S_RUN;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl (NIBBLES = 4): directed corner cases
// plus randomized operations against an arithmetic reference model.
module tb_addsub_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks;
    int n_fail;

    addsub_seq_ctrl #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic on integers, not nibble-serial.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        int unsigned ux, uy, r;
        logic        c, v;
        int          sx, sy, sr;
        ux = x;
        uy = y;
        if (o) begin
            r  = (ux - uy) & 32'h0000_FFFF;
            c  = (ux < uy);
        end else begin
            r  = (ux + uy) & 32'h0000_FFFF;
            c  = ((ux + uy) > 32'h0000_FFFF);
        end
        sx = (ux >= 32'd32768) ? int'(ux) - 65536 : int'(ux);
        sy = (uy >= 32'd32768) ? int'(uy) - 65536 : int'(uy);
        sr = o ? (sx - sy) : (sx + sy);
        v  = (sr > 32767) || (sr < -32768);
        return {v, c, r[W-1:0]};
    endfunction

    // Drive a start at the current negedge; return at the negedge of cycle 1.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        start = 1'b1;
        a     = x;
        b     = y;
        op    = o;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 1'($urandom);
    endtask

    // Wait (bounded) for done; optionally pulse a stray start at cycle inj.
    task automatic wait_done(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic o, input int inj);
        logic [W+1:0] exp;
        int lat;
        exp = model(x, y, o);
        lat = 1;
        while (done !== 1'b1 && lat <= 12) begin
            check_eq({tag, ".busy"}, 32'(busy), 32'(lat <= N));
            start = (lat == inj) ? 1'b1 : 1'b0;
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(N + 1));
        check_eq({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, ".result"}, 32'(result), 32'(exp[W-1:0]));
        check_eq({tag, ".cout"}, 32'(cout), 32'(exp[W]));
        check_eq({tag, ".ovf"}, 32'(ovf), 32'(exp[W+1]));
    endtask

    // Cycle after done: pulse gone, outputs held.
    task automatic check_hold(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        logic [W+1:0] exp;
        exp = model(x, y, o);
        @(negedge clk);
        check_eq({tag, ".done_once"}, 32'(done), 32'd0);
        check_eq({tag, ".hold"}, 32'({ovf, cout, result}), 32'(exp));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        issue(x, y, o);
        wait_done(tag, x, y, o, 0);
        check_hold(tag, x, y, o);
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic         o;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        a        = '0;
        b        = '0;

        #12;
        check_eq("reset.outputs", 32'({busy, done, ovf, cout, result}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First start immediately after reset release.
        run_op("add", 16'h1234, 16'h0FFF, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1);
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1);
        run_op("sub_zero", 16'hABCD, 16'hABCD, 1'b1);

        // Stray start in cycle 2 must be ignored.
        issue(16'h1111, 16'h2222, 1'b0);
        wait_done("start_in_run", 16'h1111, 16'h2222, 1'b0, 2);
        check_hold("start_in_run", 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        check_eq("start_in_run.idle_busy", 32'(busy), 32'd0);

        // Back-to-back: start during the DONE cycle.
        issue(16'h4000, 16'h0123, 1'b1);
        wait_done("b2b_first", 16'h4000, 16'h0123, 1'b1, 0);
        issue(16'hFFFF, 16'h0001, 1'b0);
        check_eq("b2b.busy_next", 32'(busy), 32'd1);
        check_eq("b2b.done_low", 32'(done), 32'd0);
        wait_done("b2b_second", 16'hFFFF, 16'h0001, 1'b0, 0);
        check_hold("b2b_second", 16'hFFFF, 16'h0001, 1'b0);

        // Reset in the middle of RUN (cycle 3).
        issue(16'h5555, 16'h3333, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midreset.outputs", 32'({busy, done, ovf, cout, result}), 32'd0);
        @(negedge clk);
        check_eq("midreset.held", 32'({busy, done, ovf, cout, result}), 32'd0);
        rst_n = 1'b1;
        run_op("after_reset", 16'h8001, 16'h7FFF, 1'b1);

        // Randomized operations, some back-to-back.
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            o = 1'($urandom);
            if (i % 8 == 0) y = x;
            issue(x, y, o);
            wait_done("rand", x, y, o, (i % 5 == 0) ? 3 : 0);
            if ($urandom_range(0, 1) == 0) begin
                check_hold("rand", x, y, o);
            end else begin
                x = W'($urandom);
                y = W'($urandom);
                o = 1'($urandom);
                issue(x, y, o);
                check_eq("rand_b2b.busy", 32'(busy), 32'd1);
                wait_done("rand_b2b", x, y, o, 0);
                check_hold("rand_b2b", x, y, o);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
